// File: rtl/rom_download_loader.sv
`timescale 1ns/1ps
// rom_download_loader
// Bridges the hps_io ioctl download stream to the game core ROM load port.
// Every downloaded byte is registered and range-checked before it reaches the
// core, and the block keeps a per-load byte count and an 8-bit checksum.
// The core stays in reset for the whole download and for a settle delay
// after it, and is released only once that delay has elapsed.
//
// Ports
//   clk_25          in   sole clock (hps_io / core domain)
//   RESET_L         in   synchronous active-low reset
//   ioctl_download  in   download window from hps_io
//   ioctl_wr        in   byte strobe, 1-cycle pulse
//   ioctl_addr      in   [24:0] byte address
//   ioctl_dout      in   [7:0] byte data
//   sys_reset       in   OSD/button reset request, active high
//   dn_addr         out  [15:0] ROM write address to core
//   dn_data         out  [7:0] ROM write data to core
//   dn_wr           out  ROM write strobe to core (1-cycle pulse)
//   core_reset_l    out  core reset, active low
//   load_done       out  high once a load completed with no overrun
//   overrun         out  sticky: an out-of-range write was dropped this load
//   byte_count      out  [15:0] accepted bytes this load, saturating
//   checksum        out  [7:0] sum mod 256 of accepted bytes this load
//   dbg_state       out  [1:0] current FSM state (IDLE=0 LOAD=1 HOLD=2 RUN=3)
//
// Handshake: ioctl_wr is a qualifier-free strobe; a byte is taken on every
// cycle where ioctl_download & ioctl_wr are both high (no back-pressure).
// dn_wr is a 1-cycle pulse with dn_addr/dn_data valid in the same cycle; the
// core has no ready, it must accept every pulse.
module rom_download_loader #(
    parameter int ADDR_LIMIT  = 10240,
    parameter int HOLD_CYCLES = 16
) (
    input  logic        clk_25,
    input  logic        RESET_L,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        sys_reset,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset_l,
    output logic        load_done,
    output logic        overrun,
    output logic [15:0] byte_count,
    output logic [7:0]  checksum,
    output logic [1:0]  dbg_state
);

    localparam int HCW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] dn_addr_q, dn_addr_d;
    logic [7:0]  dn_data_q, dn_data_d;
    logic        dn_wr_q, dn_wr_d;
    logic        core_reset_l_q, core_reset_l_d;
    logic        load_done_q, load_done_d;
    logic        overrun_q, overrun_d;
    logic [15:0] byte_count_q, byte_count_d;
    logic [7:0]  checksum_q, checksum_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

    logic        wr_req;
    logic        in_range;
    logic        accept;
    logic        drop;
    logic        load_entry;
    logic [15:0] base_count;
    logic [7:0]  base_sum;

    always_comb begin
        wr_req     = ioctl_download & ioctl_wr;
        in_range   = ioctl_addr < 25'(ADDR_LIMIT);
        accept     = wr_req & in_range;
        drop       = wr_req & ~in_range;
        // Any edge that moves the FSM into LOAD starts a fresh load; a byte
        // accepted on that same edge is counted as the first byte.
        load_entry = ioctl_download & (state_q != ST_LOAD);
        base_count = load_entry ? 16'd0 : byte_count_q;
        base_sum   = load_entry ? 8'd0  : checksum_q;
    end

    always_comb begin
        state_d        = state_q;
        dn_addr_d      = dn_addr_q;
        dn_data_d      = dn_data_q;
        dn_wr_d        = accept;
        core_reset_l_d = 1'b0;
        load_done_d    = load_done_q;
        overrun_d      = (load_entry ? 1'b0 : overrun_q) | drop;
        byte_count_d   = base_count;
        checksum_d     = base_sum + (accept ? ioctl_dout : 8'd0);
        hold_cnt_d     = hold_cnt_q;

        if (accept) begin
            dn_addr_d = ioctl_addr[15:0];
            dn_data_d = ioctl_dout;
            if (base_count != 16'hFFFF) begin
                byte_count_d = base_count + 16'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (ioctl_download) begin
                    state_d     = ST_LOAD;
                    load_done_d = 1'b0;
                end
            end
            ST_LOAD: begin
                load_done_d = 1'b0;
                if (!ioctl_download) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + HCW'(1);
                if (ioctl_download) begin
                    state_d     = ST_LOAD;
                    load_done_d = 1'b0;
                end else if (hold_cnt_q == HCW'(HOLD_CYCLES - 1)) begin
                    // Dropped bytes do not block release; they only withhold load_done.
                    state_d     = ST_RUN;
                    load_done_d = ~overrun_q;
                end
            end
            ST_RUN: begin
                if (ioctl_download) begin
                    state_d     = ST_LOAD;
                    load_done_d = 1'b0;
                end else begin
                    core_reset_l_d = ~sys_reset;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_25) begin
        if (!RESET_L) begin
            state_q        <= ST_IDLE;
            dn_addr_q      <= '0;
            dn_data_q      <= '0;
            dn_wr_q        <= 1'b0;
            core_reset_l_q <= 1'b0;
            load_done_q    <= 1'b0;
            overrun_q      <= 1'b0;
            byte_count_q   <= '0;
            checksum_q     <= '0;
            hold_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            dn_addr_q      <= dn_addr_d;
            dn_data_q      <= dn_data_d;
            dn_wr_q        <= dn_wr_d;
            core_reset_l_q <= core_reset_l_d;
            load_done_q    <= load_done_d;
            overrun_q      <= overrun_d;
            byte_count_q   <= byte_count_d;
            checksum_q     <= checksum_d;
            hold_cnt_q     <= hold_cnt_d;
        end
    end

    assign dn_addr      = dn_addr_q;
    assign dn_data      = dn_data_q;
    assign dn_wr        = dn_wr_q;
    assign core_reset_l = core_reset_l_q;
    assign load_done    = load_done_q;
    assign overrun      = overrun_q;
    assign byte_count   = byte_count_q;
    assign checksum     = checksum_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_rom_download_loader.sv
`timescale 1ns/1ps
module tb_rom_download_loader;

  localparam int ADDR_LIMIT  = 10240;
  localparam int HOLD_CYCLES = 16;

  // ---------------- clock / reset / DUT ----------------
  logic        clk_25 = 1'b0;
  logic        RESET_L = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        sys_reset = 1'b0;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        core_reset_l;
  logic        load_done;
  logic        overrun;
  logic [15:0] byte_count;
  logic [7:0]  checksum;
  logic [1:0]  dbg_state;

  always #20 clk_25 = ~clk_25;

  int unsigned cyc = 0;
  always @(posedge clk_25) cyc <= cyc + 1;

  rom_download_loader #(
    .ADDR_LIMIT (ADDR_LIMIT),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk_25        (clk_25),
    .RESET_L       (RESET_L),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .sys_reset     (sys_reset),
    .dn_addr       (dn_addr),
    .dn_data       (dn_data),
    .dn_wr         (dn_wr),
    .core_reset_l  (core_reset_l),
    .load_done     (load_done),
    .overrun       (overrun),
    .byte_count    (byte_count),
    .checksum      (checksum),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [23:0] exp_q[$];       // {dn_addr, dn_data} expected per forwarded byte
  int unsigned stamp_q[$];     // cycle count when the byte was driven

  logic [7:0] t2_data [4] = '{8'h10, 8'h20, 8'h30, 8'hF5};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every dn_wr pulse must match the oldest queued byte and appear exactly
  // one clock after its ioctl_wr was sampled.
  always @(negedge clk_25) begin
    logic [23:0] e;
    int unsigned s;
    if (dn_wr !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("dn_wr_unexpected", 32'(dn_wr), 32'd0);
      end else begin
        e = exp_q.pop_front();
        s = stamp_q.pop_front();
        check("dn_word", 32'({dn_addr, dn_data}), 32'(e));
        check("dn_latency", 32'(cyc), 32'(s + 1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_25);
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (ioctl_download && (a < 25'(ADDR_LIMIT))) begin
      exp_q.push_back({a[15:0], d});
      stamp_q.push_back(cyc);
    end
    @(negedge clk_25);
    ioctl_wr = 1'b0;
    @(negedge clk_25);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  // Release timing: the edge that first samples ioctl_download=0 is E0; the
  // hold counter reaches HOLD_CYCLES-1 at E16 (enter RUN) and core_reset_l
  // rises at E17. After driving the fall at a negedge, 17 negedges cover
  // E0..E16 (still low) and the 18th covers E17 (high).
  initial begin
    // T1: reset with strobes toggling
    RESET_L = 1'b0;
    ioctl_download = 1'b1;
    @(negedge clk_25);
    for (int i = 0; i < 3; i++) begin
      ioctl_wr   = ~ioctl_wr;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'(8'hA0 + i);
      @(negedge clk_25);
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    check("t1_dn_addr",  32'(dn_addr), 32'd0);
    check("t1_dn_data",  32'(dn_data), 32'd0);
    check("t1_dn_wr",    32'(dn_wr), 32'd0);
    check("t1_core",     32'(core_reset_l), 32'd0);
    check("t1_done",     32'(load_done), 32'd0);
    check("t1_overrun",  32'(overrun), 32'd0);
    check("t1_count",    32'(byte_count), 32'd0);
    check("t1_checksum", 32'(checksum), 32'd0);
    RESET_L = 1'b1;
    tick(2);
    check("t1_idle_core",  32'(core_reset_l), 32'd0);
    check("t1_idle_state", 32'(dbg_state), 32'd0);

    // T2: four-byte load
    ioctl_download = 1'b1;
    tick(2);
    for (int i = 0; i < 4; i++) wr_byte(25'(i), t2_data[i]);
    check("t2_count",       32'(byte_count), 32'd4);
    check("t2_checksum",    32'(checksum), 32'h55);
    check("t2_core_load",   32'(core_reset_l), 32'd0);
    check("t2_done_load",   32'(load_done), 32'd0);
    ioctl_download = 1'b0;
    tick(17);
    check("t2_core_e16",    32'(core_reset_l), 32'd0);
    tick(1);
    check("t2_core_e17",    32'(core_reset_l), 32'd1);
    check("t2_done",        32'(load_done), 32'd1);
    check("t2_overrun",     32'(overrun), 32'd0);
    check("t2_hold_addr",   32'(dn_addr), 32'd3);
    check("t2_hold_data",   32'(dn_data), 32'hF5);
    check("t2_count_run",   32'(byte_count), 32'd4);

    // T3: boundary addresses 10239 (kept) and 10240 (dropped)
    ioctl_download = 1'b1;
    tick(1);
    check("t3_core_reload", 32'(core_reset_l), 32'd0);
    check("t3_count_clr",   32'(byte_count), 32'd0);
    tick(1);
    wr_byte(25'd10239, 8'hAB);
    wr_byte(25'd10240, 8'hCD);
    check("t3_overrun",     32'(overrun), 32'd1);
    check("t3_count",       32'(byte_count), 32'd1);
    check("t3_checksum",    32'(checksum), 32'hAB);
    check("t3_addr",        32'(dn_addr), 32'h27FF);
    check("t3_data",        32'(dn_data), 32'hAB);
    ioctl_download = 1'b0;
    tick(18);
    check("t3_core_run",    32'(core_reset_l), 32'd1);
    check("t3_done",        32'(load_done), 32'd0);
    check("t3_overrun_run", 32'(overrun), 32'd1);

    // T4: restart during HOLD
    ioctl_download = 1'b1;
    tick(2);
    wr_byte(25'd5, 8'h11);
    check("t4_count_a",     32'(byte_count), 32'd1);
    ioctl_download = 1'b0;
    tick(9);
    check("t4_state_hold",  32'(dbg_state), 32'd2);
    ioctl_download = 1'b1;
    tick(1);
    check("t4_state_load",  32'(dbg_state), 32'd1);
    check("t4_count_clr",   32'(byte_count), 32'd0);
    check("t4_sum_clr",     32'(checksum), 32'd0);
    check("t4_core",        32'(core_reset_l), 32'd0);
    check("t4_overrun_clr", 32'(overrun), 32'd0);
    wr_byte(25'd7, 8'h22);
    check("t4_count_b",     32'(byte_count), 32'd1);
    check("t4_sum_b",       32'(checksum), 32'h22);
    ioctl_download = 1'b0;
    tick(17);
    check("t4_core_e16",    32'(core_reset_l), 32'd0);
    tick(1);
    check("t4_core_e17",    32'(core_reset_l), 32'd1);
    check("t4_done",        32'(load_done), 32'd1);

    // T5: sys_reset pulse in RUN, then reload from RUN
    sys_reset = 1'b1;
    check("t5_core_pre",    32'(core_reset_l), 32'd1);
    tick(1);
    check("t5_core_s0",     32'(core_reset_l), 32'd0);
    tick(1);
    check("t5_core_s1",     32'(core_reset_l), 32'd0);
    sys_reset = 1'b0;
    tick(1);
    check("t5_core_s2",     32'(core_reset_l), 32'd1);
    check("t5_done_kept",   32'(load_done), 32'd1);
    check("t5_count_kept",  32'(byte_count), 32'd1);
    check("t5_sum_kept",    32'(checksum), 32'h22);
    ioctl_download = 1'b1;
    tick(1);
    check("t5_core_reload", 32'(core_reset_l), 32'd0);
    check("t5_done_reload", 32'(load_done), 32'd0);
    check("t5_count_clr",   32'(byte_count), 32'd0);
    ioctl_download = 1'b0;
    tick(18);
    check("t5_empty_core",  32'(core_reset_l), 32'd1);
    check("t5_empty_done",  32'(load_done), 32'd1);
    check("t5_empty_count", 32'(byte_count), 32'd0);

    // T6: stray writes outside the download window, in RUN and in IDLE
    wr_byte(25'd2, 8'h77);
    check("t6_run_count",   32'(byte_count), 32'd0);
    check("t6_run_sum",     32'(checksum), 32'd0);
    check("t6_run_addr",    32'(dn_addr), 32'd7);
    check("t6_run_data",    32'(dn_data), 32'h22);
    check("t6_run_core",    32'(core_reset_l), 32'd1);
    RESET_L = 1'b0;
    tick(1);
    RESET_L = 1'b1;
    tick(1);
    check("t6_idle_state",  32'(dbg_state), 32'd0);
    wr_byte(25'd1, 8'h55);
    check("t6_idle_count",  32'(byte_count), 32'd0);
    check("t6_idle_addr",   32'(dn_addr), 32'd0);
    check("t6_idle_core",   32'(core_reset_l), 32'd0);

    tick(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
